// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage sitting directly upstream of the instruction memory.
// Owns the program counter, presents a word index to the memory (which answers
// combinationally in the same cycle) and captures the returned instruction
// together with its PC into the IF/ID register for the decoder.
//
// Ports:
//   clk          single clock, all state updates on the rising edge
//   rst          synchronous active-high reset (overrides stall and redirect)
//   imem_addr    word index {2'b00, pc[31:2]} to the instruction memory
//   imem_inst    instruction returned combinationally for imem_addr
//   stall        downstream hazard hold: freezes pc, IF/ID and fetch_count
//   redirect     taken branch/jump from a later stage (beats stall)
//   redirect_pc  byte target of the redirect (accepted even if misaligned)
//   if_id_valid  IF/ID holds a real instruction
//   if_id_pc     byte PC of the IF/ID instruction
//   if_id_inst   instruction word in IF/ID (NOP_INST on a faulting fetch)
//   if_id_fault  IF/ID entry came from a misaligned or out-of-range fetch
//   pc           current fetch PC (byte address)
//   fetch_count  number of instructions latched with if_id_valid=1
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 1024,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_inst,
    output logic        if_id_fault,
    output logic [31:0] pc,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] DEPTH_WORDS = 32'(IMEM_DEPTH);

    // A fetch faults when the byte address is not word aligned or the word
    // index falls past the end of the instruction memory.
    function automatic logic fetch_fault(input logic [31:0] addr);
        logic [31:0] word_idx;
        word_idx    = {2'b00, addr[31:2]};
        fetch_fault = (addr[1:0] != 2'b00) || (word_idx >= DEPTH_WORDS);
    endfunction

    logic fault;

    assign imem_addr = {2'b00, pc[31:2]};
    assign fault     = fetch_fault(pc);

    // Fetch PC -> IF/ID boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            if_id_valid <= 1'b0;
            if_id_pc    <= 32'h0000_0000;
            if_id_inst  <= NOP_INST;
            if_id_fault <= 1'b0;
            fetch_count <= 32'h0000_0000;
        end else if (redirect) begin
            // Wrong-path instruction at the old pc is dropped; if_id_pc and
            // if_id_inst keep their stale values behind a cleared valid bit.
            pc          <= redirect_pc;
            if_id_valid <= 1'b0;
            if_id_fault <= 1'b0;
        end else if (!stall) begin
            pc          <= pc + 32'd4;
            if_id_valid <= 1'b1;
            if_id_pc    <= pc;
            if_id_inst  <= fault ? NOP_INST : imem_inst;
            if_id_fault <= fault;
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;
    logic        if_id_fault;
    logic [31:0] pc;
    logic [31:0] fetch_count;

    logic [31:0] mem [0:1023];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Bench-side reference state
    logic [31:0] m_pc;
    logic [31:0] m_count;

    fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_DEPTH (1024),
        .NOP_INST   (NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_inst   (imem_inst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_id_valid (if_id_valid),
        .if_id_pc    (if_id_pc),
        .if_id_inst  (if_id_inst),
        .if_id_fault (if_id_fault),
        .pc          (pc),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_inst = (imem_addr < 32'd1024) ? mem[imem_addr[9:0]] : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One advancing edge: reference result queued before the edge, popped and
    // compared once the IF/ID register has taken it.
    task automatic advance(input string tag);
        exp_t e;
        exp_t got;
        e.pc    = m_pc;
        e.fault = (m_pc[1:0] != 2'b00) || ({2'b00, m_pc[31:2]} >= 32'd1024);
        e.inst  = e.fault ? NOP : mem[m_pc[11:2]];
        exp_q.push_back(e);
        check({tag, "_imem_addr"}, imem_addr, {2'b00, m_pc[31:2]});
        stall    = 1'b0;
        redirect = 1'b0;
        step();
        m_pc    = m_pc + 32'd4;
        m_count = m_count + 32'd1;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            got = exp_q.pop_front();
            check({tag, "_if_id_pc"}, if_id_pc, got.pc);
            check({tag, "_if_id_inst"}, if_id_inst, got.inst);
            check({tag, "_if_id_fault"}, {31'd0, if_id_fault}, {31'd0, got.fault});
        end
        check({tag, "_valid"}, {31'd0, if_id_valid}, 32'd1);
        check({tag, "_pc"}, pc, m_pc);
        check({tag, "_count"}, fetch_count, m_count);
    endtask

    task automatic do_redirect(input logic [31:0] target, input logic with_stall, input string tag);
        logic [31:0] hold_pc;
        hold_pc     = if_id_pc;
        stall       = with_stall;
        redirect    = 1'b1;
        redirect_pc = target;
        step();
        redirect = 1'b0;
        stall    = 1'b0;
        m_pc     = target;
        check({tag, "_pc"}, pc, target);
        check({tag, "_valid"}, {31'd0, if_id_valid}, 32'd0);
        check({tag, "_fault"}, {31'd0, if_id_fault}, 32'd0);
        check({tag, "_if_id_pc_hold"}, if_id_pc, hold_pc);
        check({tag, "_count"}, fetch_count, m_count);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 | i;
        mem[0] = 32'h0020_8033;
        mem[1] = 32'h4020_8033;

        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        step();
        step();
        rst     = 1'b0;
        m_pc    = 32'h0;
        m_count = 32'h0;

        // Reset state
        check("rst_pc", pc, 32'h0);
        check("rst_valid", {31'd0, if_id_valid}, 32'd0);
        check("rst_if_id_pc", if_id_pc, 32'h0);
        check("rst_if_id_inst", if_id_inst, NOP);
        check("rst_fault", {31'd0, if_id_fault}, 32'd0);
        check("rst_count", fetch_count, 32'd0);
        check("rst_imem_addr", imem_addr, 32'd0);

        // Sequential fetch
        advance("seq0");
        check("seq0_inst_lit", if_id_inst, 32'h0020_8033);
        advance("seq1");
        check("seq1_inst_lit", if_id_inst, 32'h4020_8033);
        check("seq1_pc_lit", pc, 32'h8);

        // Stall for three cycles
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", pc, 32'h8);
            check("stall_if_id_pc", if_id_pc, 32'h4);
            check("stall_if_id_inst", if_id_inst, 32'h4020_8033);
            check("stall_valid", {31'd0, if_id_valid}, 32'd1);
            check("stall_count", fetch_count, 32'd2);
        end
        stall = 1'b0;
        advance("unstall");

        // Redirect beats stall
        do_redirect(32'h40, 1'b1, "redir_stall");
        advance("redir_fetch");
        check("redir_fetch_pc_lit", if_id_pc, 32'h40);

        // Last valid word, then out of range
        do_redirect(32'hFFC, 1'b0, "redir_last");
        advance("last_word");
        check("last_word_fault_lit", {31'd0, if_id_fault}, 32'd0);
        check("oor_pc_lit", pc, 32'h1000);
        advance("oor");
        check("oor_inst_lit", if_id_inst, NOP);
        check("oor_pc_after", pc, 32'h1004);

        // Misaligned redirect
        do_redirect(32'h6, 1'b0, "redir_mis");
        advance("misaligned");
        check("misaligned_fault_lit", {31'd0, if_id_fault}, 32'd1);
        check("misaligned_pc_step", pc, 32'hA);

        // PC wrap at 2^32
        do_redirect(32'hFFFF_FFFC, 1'b0, "redir_wrap");
        advance("wrap");

        // Reset mid-run with redirect asserted
        do_redirect(32'h1C, 1'b0, "redir_pre_rst");
        advance("pre_rst");
        check("pre_rst_pc_lit", pc, 32'h20);
        rst         = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        step();
        rst      = 1'b0;
        redirect = 1'b0;
        check("midrst_pc", pc, 32'h0);
        check("midrst_valid", {31'd0, if_id_valid}, 32'd0);
        check("midrst_count", fetch_count, 32'd0);
        check("midrst_if_id_inst", if_id_inst, NOP);
        check("midrst_if_id_pc", if_id_pc, 32'h0);
        check("midrst_queue_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction memory.
- Owns the program counter and drives a word-index address to the memory, which returns the instruction combinationally in the same cycle.
- Captures the returned instruction and its PC into an IF/ID pipeline register for the decoder.
- Handles stall, branch/jump redirect, flush, out-of-range fetch faults, and counts fetched instructions.

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset; must be 4-byte aligned.
- IMEM_DEPTH, 1024, number of 32-bit words in the instruction memory.
- NOP_INST, 32'h0000_0013, instruction substituted on a fault (addi x0,x0,0).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_addr  output  32  word index to the instruction memory = {2'b00, pc[31:2]}; combinational from pc.
- imem_inst  input  32  instruction word returned combinationally for imem_addr.
- stall  input  1  hazard hold from downstream; freezes pc and IF/ID.
- redirect  input  1  taken branch/jump from a later stage.
- redirect_pc  input  32  byte target of the redirect.
- if_id_valid  output  1  IF/ID holds a real instruction.
- if_id_pc  output  32  byte PC of the IF/ID instruction.
- if_id_inst  output  32  instruction word in IF/ID.
- if_id_fault  output  1  the IF/ID entry came from a misaligned or out-of-range fetch.
- pc  output  32  current fetch PC, byte address.
- fetch_count  output  32  number of instructions latched with if_id_valid=1.

Behaviour:
- Reset, sampled on a clk edge with rst=1:
  - pc=RESET_PC; if_id_valid=0; if_id_pc=0; if_id_inst=NOP_INST; if_id_fault=0; fetch_count=0.
  - rst overrides stall and redirect. Reset mid-operation discards any in-flight IF/ID content.
- Fetch is combinational:
  - imem_addr is derived from pc in the same cycle.
  - imem_inst is sampled at the following edge, so IF/ID latency is 1 cycle from pc.
- Fault detection (combinational on the current pc):
  - fault = (pc[1:0] != 0) OR (pc[31:2] >= IMEM_DEPTH).
  - On fault, IF/ID captures NOP_INST instead of imem_inst and sets if_id_fault=1.
- Per-edge priority when rst=0: redirect > stall > advance.
  - REDIRECT (redirect=1, stall ignored): pc <= redirect_pc; if_id_valid <= 0; if_id_fault <= 0; if_id_pc and if_id_inst hold. fetch_count unchanged. The wrong-path instruction at the old pc is dropped.
  - STALL (redirect=0, stall=1): pc, the entire IF/ID register and fetch_count hold.
  - ADVANCE (redirect=0, stall=0):
    - if_id_pc <= pc; if_id_inst <= fault ? NOP_INST : imem_inst; if_id_fault <= fault; if_id_valid <= 1.
    - pc <= pc + 4, wrapping modulo 2^32.
    - fetch_count <= fetch_count + 1, wrapping at 2^32.
- A misaligned redirect_pc is accepted as-is. The fault surfaces on the next ADVANCE; pc still steps by +4 after a faulting fetch, and no recovery is built in.
- No internal state machine beyond the pc, IF/ID and counter registers. if_id_valid is effectively an EMPTY/FULL bit: cleared only by reset or redirect, set by ADVANCE.

Test Plan:
- Sequential fetch:
  - Stimulus: reset with RESET_PC=0, memory words 0..1 = 32'h0020_8033 and 32'h4020_8033, then 2 advancing cycles.
  - Response: imem_addr goes 0 then 1. After edge 1: if_id_pc=0, if_id_inst=32'h0020_8033, if_id_valid=1. After edge 2: if_id_pc=4, if_id_inst=32'h4020_8033, pc=8, fetch_count=2.
- Stall:
  - Stimulus: stall=1 for 3 cycles with pc=8.
  - Response: pc, if_id_* and fetch_count are unchanged over all 3 cycles. Releasing the stall fetches word 2 on the next edge.
- Redirect during stall:
  - Stimulus: stall=1, redirect=1, redirect_pc=32'h40.
  - Response: pc=32'h40 and if_id_valid=0 after the edge. The next advance yields if_id_pc=32'h40 with imem_addr=16.
- Out-of-range fetch:
  - Stimulus: redirect_pc=32'h1000 (word 1024), then advance.
  - Response: if_id_inst=32'h0000_0013, if_id_fault=1, if_id_valid=1, pc=32'h1004.
- Misaligned redirect:
  - Stimulus: redirect_pc=32'h6, then advance.
  - Response: if_id_fault=1, if_id_inst=NOP_INST.
- Reset mid-run:
  - Stimulus: assert rst with redirect=1 and pc=32'h20.
  - Response: pc=RESET_PC, if_id_valid=0, fetch_count=0 after the edge.
